// File: rtl/life_led_serializer.sv
// Sends one 8x8 Game of Life board as a WS2812 frame. Live cells get the snapshot colour
// and dead cells are off. A latch gap follows the frame, then done pulses once.
module life_led_serializer #(
    parameter int NUM_PIXELS   = 64,
    parameter int BIT_CYCLES   = 15,
    parameter int T0H_CYCLES   = 5,
    parameter int T1H_CYCLES   = 10,
    parameter int LATCH_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_PIXELS-1:0] board,
    input  logic [23:0]           color,
    output logic                  dout,
    output logic                  busy,
    output logic                  done
);
    localparam int PW = $clog2(NUM_PIXELS);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int LW = $clog2(LATCH_CYCLES);

    localparam logic [PW-1:0] PIX_LAST   = PW'(NUM_PIXELS - 1);
    localparam logic [4:0]    BIT_LAST   = 5'd23;
    localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYCLES);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t                state;
    logic [NUM_PIXELS-1:0] board_q;
    logic [23:0]           color_q;
    logic [PW-1:0]         pix_cnt;
    logic [4:0]            bit_cnt;
    logic [CW-1:0]         cyc_cnt;
    logic [LW-1:0]         lat_cnt;

    // Position of the cycle after this one; dout is registered, so it is computed one slot ahead.
    logic [PW-1:0] nxt_pix;
    logic [4:0]    nxt_bit;
    logic [CW-1:0] nxt_cyc;
    logic          last_slot;
    logic          nxt_val;

    always_comb begin
        nxt_pix   = pix_cnt;
        nxt_bit   = bit_cnt;
        nxt_cyc   = cyc_cnt + 1'b1;
        last_slot = 1'b0;
        if (cyc_cnt == CYC_LAST) begin
            nxt_cyc = '0;
            if (bit_cnt == BIT_LAST) begin
                nxt_bit = '0;
                if (pix_cnt == PIX_LAST) begin
                    last_slot = 1'b1;
                end else begin
                    nxt_pix = pix_cnt + 1'b1;
                end
            end else begin
                nxt_bit = bit_cnt + 1'b1;
            end
        end
        nxt_val = board_q[nxt_pix] & color_q[5'd23 - nxt_bit];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            board_q <= '0;
            color_q <= '0;
            pix_cnt <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            lat_cnt <= '0;
            dout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    dout <= 1'b0;
                    // A start coinciding with done is dropped: a new frame needs a true idle cycle.
                    if (start && !done) begin
                        board_q <= board;
                        color_q <= color;
                        pix_cnt <= '0;
                        bit_cnt <= '0;
                        cyc_cnt <= '0;
                        state   <= SEND;
                        busy    <= 1'b1;
                        dout    <= 1'b1;  // every bit slot opens high
                    end
                end
                SEND: begin
                    if (last_slot) begin
                        state   <= LATCH;
                        lat_cnt <= '0;
                        dout    <= 1'b0;
                    end else begin
                        pix_cnt <= nxt_pix;
                        bit_cnt <= nxt_bit;
                        cyc_cnt <= nxt_cyc;
                        dout    <= nxt_cyc < (nxt_val ? T1H : T0H);
                    end
                end
                LATCH: begin
                    dout <= 1'b0;
                    if (lat_cnt == LATCH_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_led_serializer.sv
// Bench for life_led_serializer: captures each frame's waveform, decodes the high pulse
// widths back into pixels and compares them with pixels built from the board and colour.
module tb_life_led_serializer;
    localparam int NP       = 64;
    localparam int BC       = 5;
    localparam int T0       = 1;
    localparam int T1       = 3;
    localparam int LC       = 37;
    localparam int SEND_CYC = NP * 24 * BC;
    localparam int FRAME    = SEND_CYC + LC;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NP-1:0] board;
    logic [23:0]   color;
    logic          dout;
    logic          busy;
    logic          done;

    int n_cmp;
    int n_bad;
    int pulse1;
    int pulse2;
    int chg_at;

    logic        wave   [FRAME+4];
    logic        done_w [FRAME+4];
    logic        busy_w [FRAME+4];
    logic [23:0] exp_q  [$];

    life_led_serializer #(
        .NUM_PIXELS  (NP),
        .BIT_CYCLES  (BC),
        .T0H_CYCLES  (T0),
        .T1H_CYCLES  (T1),
        .LATCH_CYCLES(LC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .board(board),
        .color(color),
        .dout (dout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue_start(input logic [NP-1:0] b, input logic [23:0] col);
        @(negedge clk);
        board = b;
        color = col;
        start = 1'b1;
    endtask

    // Sample index k holds the outputs just after the k-th rising edge following the start edge.
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            wave[k]   = dout;
            done_w[k] = done;
            busy_w[k] = busy;
            start = (k == pulse1) || (k == pulse2);
            if (k == chg_at) begin
                board = ~board;
                color = ~color;
            end
        end
        pulse1 = -1;
        pulse2 = -1;
        chg_at = -1;
    endtask

    task automatic check_frame(input string name, input logic [NP-1:0] b, input logic [23:0] col);
        int bad_slots;
        int latch_hi;
        int n_done;
        int first_done;
        int h;
        int base;
        logic bitv;
        logic [23:0] got;
        logic [23:0] exp_px;
        exp_q.delete();
        for (int p = 0; p < NP; p++) exp_q.push_back(b[p] ? col : 24'h000000);
        bad_slots = 0;
        for (int p = 0; p < NP; p++) begin
            got = '0;
            for (int i = 0; i < 24; i++) begin
                base = (p * 24 + i) * BC;
                h = 0;
                while (h < BC && wave[base + h] === 1'b1) h++;
                for (int j = h; j < BC; j++) if (wave[base + j] !== 1'b0) bad_slots++;
                bitv = 1'b0;
                if (h == T1) bitv = 1'b1;
                else if (h != T0) bad_slots++;
                got = {got[22:0], bitv};
            end
            exp_px = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_px) begin
                n_bad++;
                $display("FAIL %s pixel %0d: got %h expected %h", name, p, got, exp_px);
            end
        end
        n_cmp++;
        if (bad_slots != 0) begin
            n_bad++;
            $display("FAIL %s slot_shape: %0d malformed slots, expected 0", name, bad_slots);
        end
        latch_hi = 0;
        for (int k = SEND_CYC; k <= FRAME; k++) if (wave[k] !== 1'b0) latch_hi++;
        n_cmp++;
        if (latch_hi != 0) begin
            n_bad++;
            $display("FAIL %s latch_low: %0d high cycles in gap, expected 0", name, latch_hi);
        end
        n_done = 0;
        first_done = -1;
        for (int k = 0; k <= FRAME; k++) begin
            if (done_w[k] === 1'b1) begin
                if (first_done < 0) first_done = k;
                n_done++;
            end
        end
        n_cmp++;
        if (first_done != FRAME || n_done != 1) begin
            n_bad++;
            $display("FAIL %s done_timing: first at %0d count %0d, expected at %0d count 1",
                     name, first_done, n_done, FRAME);
        end
        n_cmp++;
        if ({busy_w[0], busy_w[FRAME-1], busy_w[FRAME]} !== 3'b110) begin
            n_bad++;
            $display("FAIL %s busy_window: got %b%b%b expected 110",
                     name, busy_w[0], busy_w[FRAME-1], busy_w[FRAME]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        board = '0;
        color = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dout, busy, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 000", {dout, busy, done});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({dout, busy, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_outputs: got %b expected 000", {dout, busy, done});
        end
    endtask

    task automatic test_frame(input string name, input logic [NP-1:0] b, input logic [23:0] col);
        issue_start(b, col);
        capture(FRAME + 1);
        check_frame(name, b, col);
    endtask

    task automatic test_ignored_start();
        logic [NP-1:0] b;
        logic [23:0] col;
        b   = {$urandom, $urandom};
        col = 24'($urandom);
        issue_start(b, col);
        chg_at = 50;
        pulse1 = 100;
        pulse2 = SEND_CYC - 40;
        capture(FRAME + 2);
        check_frame("ignored_start", b, col);
        n_cmp++;
        if (busy_w[FRAME+1] !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_start_no_restart: busy %b expected 0", busy_w[FRAME+1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [NP-1:0] b;
        logic [23:0] col;
        logic saw_done;
        b   = {$urandom, $urandom};
        col = 24'($urandom) | 24'h800000;
        issue_start(b, col);
        capture(5001);
        n_cmp++;
        if (wave[5000] !== 1'b1 || busy_w[5000] !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset: dout %b busy %b expected 1 1", wave[5000], busy_w[5000]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dout, busy, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL async_reset: got %b expected 000", {dout, busy, done});
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_done |= (done !== 1'b0);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            saw_done |= (done !== 1'b0) || (busy !== 1'b0);
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abandon: done/busy seen %b expected 0", saw_done);
        end
        b   = {$urandom, $urandom};
        col = 24'($urandom);
        test_frame("after_reset", b, col);
    endtask

    task automatic test_back_to_back();
        logic [NP-1:0] ba;
        logic [NP-1:0] bb;
        logic [23:0] ca;
        logic [23:0] cb;
        ba = {$urandom, $urandom};
        bb = {$urandom, $urandom};
        ca = 24'($urandom);
        cb = 24'($urandom);
        issue_start(ba, ca);
        pulse1 = FRAME;
        capture(FRAME + 1);
        check_frame("b2b_a", ba, ca);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_with_done: busy %b expected 0", busy);
        end
        board = bb;
        color = cb;
        start = 1'b1;
        capture(FRAME + 1);
        check_frame("b2b_b", bb, cb);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        pulse1 = -1;
        pulse2 = -1;
        chg_at = -1;
        test_reset();
        test_frame("all_dead", 64'h0, 24'hFFFFFF);
        test_frame("first_pixel", 64'h1, 24'h00FF00);
        test_frame("last_pixel", 64'h8000_0000_0000_0000, 24'hA5A5A5);
        test_ignored_start();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
